// File: rtl/unsigned_serial_subtractor.sv
// Serial unsigned subtractor: o_diff = i_a - i_b, CHUNK bits per clock,
// LSB chunk first, with a registered borrow chain and valid/ready on both sides.
module unsigned_serial_subtractor #(
  parameter  int AWIDTH = 16,
  parameter  int BWIDTH = 16,
  parameter  int CHUNK  = 4,
  localparam int MAXW   = (AWIDTH > BWIDTH) ? AWIDTH : BWIDTH,
  localparam int OUTWID = MAXW + 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [AWIDTH-1:0] i_a,
  input  logic [BWIDTH-1:0] i_b,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [OUTWID-1:0] o_diff,
  output logic              o_borrow
);

  localparam int NCHUNK = (OUTWID + CHUNK - 1) / CHUNK;
  localparam int EXTW   = NCHUNK * CHUNK;
  localparam int LASTW  = OUTWID - (NCHUNK - 1) * CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t            state;
  logic [EXTW-1:0]   a_q;
  logic [EXTW-1:0]   b_q;
  logic              borrow_q;
  logic [CW-1:0]     cnt;
  logic [CHUNK:0]    sub;
  logic              last;
  logic [OUTWID-1:0] diff_nxt;

  assign sub  = {1'b0, a_q[CHUNK-1:0]}
              - {1'b0, b_q[CHUNK-1:0]}
              - {{CHUNK{1'b0}}, borrow_q};
  assign last = (cnt == CW'(NCHUNK - 1));

  // Chunks enter at the top and shift down; the final chunk is narrowed
  // to LASTW so chunk 0 lands exactly on bit 0 after the last step.
  generate
    if (NCHUNK == 1) begin : g_one
      assign diff_nxt = sub[CHUNK-1:0];
    end else begin : g_many
      assign diff_nxt = last
        ? {sub[LASTW-1:0], o_diff[OUTWID-1:LASTW]}
        : {sub[CHUNK-1:0], o_diff[OUTWID-1:CHUNK]};
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state    <= IDLE;
      o_ready  <= 1'b1;
      o_valid  <= 1'b0;
      o_diff   <= '0;
      o_borrow <= 1'b0;
      borrow_q <= 1'b0;
      cnt      <= '0;
      a_q      <= '0;
      b_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            a_q      <= EXTW'(i_a);
            b_q      <= EXTW'(i_b);
            borrow_q <= 1'b0;
            cnt      <= '0;
            o_ready  <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          o_diff   <= diff_nxt;
          borrow_q <= sub[CHUNK];
          a_q      <= a_q >> CHUNK;
          b_q      <= b_q >> CHUNK;
          cnt      <= cnt + CW'(1);
          if (last) begin
            o_borrow <= sub[CHUNK];
            o_valid  <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            o_ready <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_unsigned_serial_subtractor.sv
// Bench for unsigned_serial_subtractor: directed and random operands
// against an arithmetic reference, at CHUNK = 4, 1 and 17.
module tb_unsigned_serial_subtractor;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] a, b;
  logic        v0, r0, ov0, ir0, bo0;
  logic [16:0] d0;
  logic        v1, r1, ov1, ir1, bo1;
  logic [16:0] d1;
  logic        v17, r17, ov17, ir17, bo17;
  logic [16:0] d17;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  unsigned_serial_subtractor dut (
    .i_clk(clk), .i_reset(rst), .i_valid(v0), .o_ready(r0),
    .i_a(a), .i_b(b), .o_valid(ov0), .i_ready(ir0),
    .o_diff(d0), .o_borrow(bo0)
  );

  unsigned_serial_subtractor #(.CHUNK(1)) dut_c1 (
    .i_clk(clk), .i_reset(rst), .i_valid(v1), .o_ready(r1),
    .i_a(a), .i_b(b), .o_valid(ov1), .i_ready(ir1),
    .o_diff(d1), .o_borrow(bo1)
  );

  unsigned_serial_subtractor #(.CHUNK(17)) dut_c17 (
    .i_clk(clk), .i_reset(rst), .i_valid(v17), .o_ready(r17),
    .i_a(a), .i_b(b), .o_valid(ov17), .i_ready(ir17),
    .o_diff(d17), .o_borrow(bo17)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [16:0] model(input logic [15:0] x, y);
    return {1'b0, x} - {1'b0, y};
  endfunction

  task automatic run0(input logic [15:0] x, y, input int hold,
                      input bit scramble);
    int n;
    logic [16:0] exp;
    exp = model(x, y);
    n = 0;
    while (!r0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("idle_ready", r0, 1);
    a = x; b = y; v0 = 1'b1;
    @(negedge clk);
    v0 = 1'b0;
    check("busy_after_accept", r0, 0);
    n = 0;
    while (!ov0 && n < 20) begin
      if (scramble) begin
        a = 16'($urandom); b = 16'($urandom); v0 = 1'($urandom);
      end
      @(negedge clk);
      n++;
      check("rdy_vld_excl", r0 & ov0, 0);
    end
    check("latency", n, 5);
    check("diff", d0, exp);
    check("borrow", bo0, exp[16]);
    check("borrow_lt", bo0, x < y);
    for (int i = 0; i < hold; i++) begin
      if (scramble) begin
        a = 16'($urandom); b = 16'($urandom); v0 = 1'($urandom);
      end
      ir0 = 1'b0;
      @(negedge clk);
      check("hold_valid", ov0, 1);
      check("hold_diff", d0, exp);
      check("hold_ready", r0, 0);
    end
    v0 = 1'b0; ir0 = 1'b1;
    @(negedge clk);
    ir0 = 1'b0;
    check("valid_drop", ov0, 0);
    check("ready_back", r0, 1);
  endtask

  task automatic run_var(input logic [15:0] x, y);
    int n, l1, l17;
    logic [16:0] exp;
    exp = model(x, y);
    check("c1_idle", r1, 1);
    check("c17_idle", r17, 1);
    a = x; b = y; v1 = 1'b1; v17 = 1'b1;
    @(negedge clk);
    v1 = 1'b0; v17 = 1'b0;
    l1 = -1; l17 = -1; n = 0;
    while ((l1 < 0 || l17 < 0) && n < 40) begin
      @(negedge clk);
      n++;
      if (ov1 && l1 < 0) l1 = n;
      if (ov17 && l17 < 0) l17 = n;
    end
    check("c1_latency", l1, 17);
    check("c17_latency", l17, 1);
    check("c1_diff", d1, exp);
    check("c1_borrow", bo1, x < y);
    check("c17_diff", d17, exp);
    check("c17_borrow", bo17, x < y);
    ir1 = 1'b1; ir17 = 1'b1;
    @(negedge clk);
    ir1 = 1'b0; ir17 = 1'b0;
    check("c1_drop", ov1, 0);
    check("c17_drop", ov17, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] x, y;
    rst = 1'b1; a = '0; b = '0;
    v0 = 0; ir0 = 0; v1 = 0; ir1 = 0; v17 = 0; ir17 = 0;
    repeat (2) @(negedge clk);
    check("rst_ready", r0, 1);
    check("rst_valid", ov0, 0);
    check("rst_diff", d0, 0);
    check("rst_borrow", bo0, 0);
    check("rst_c1_valid", ov1, 0);
    check("rst_c17_ready", r17, 1);
    rst = 1'b0;
    @(negedge clk);

    run0(16'd10, 16'd5, 0, 0);
    run0(16'd5, 16'd10, 0, 0);
    run0(16'hFFFF, 16'h0000, 0, 0);
    run0(16'h0000, 16'hFFFF, 0, 0);
    run0(16'd1234, 16'd1234, 0, 0);
    run0(16'h1000, 16'h0001, 0, 0);
    run0(16'd300, 16'd4000, 3, 1);
    run0(16'd4000, 16'd300, 3, 1);

    a = 16'd10; b = 16'd5; v0 = 1'b1;
    @(negedge clk);
    v0 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_valid", ov0, 0);
    check("midrst_ready", r0, 1);
    check("midrst_diff", d0, 0);
    check("midrst_borrow", bo0, 0);
    run0(16'd7, 16'd9, 0, 0);

    for (int i = 0; i < 30; i++) begin
      x = 16'($urandom);
      y = 16'($urandom);
      if (i % 7 == 3) x = 16'h0000;
      if (i % 11 == 5) y = 16'hFFFF;
      run0(x, y, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end

    run_var(16'h1000, 16'h0001);
    run_var(16'd10, 16'd5);
    run_var(16'h0000, 16'hFFFF);
    run_var(16'hFFFF, 16'h0000);
    for (int i = 0; i < 5; i++)
      run_var(16'($urandom), 16'($urandom));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
